// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 codes, FSM states, lane constants.
package lsu_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned MaskW = 4;
  localparam int unsigned AddrW = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [MaskW-1:0] MASK_B = 4'b0001;
  localparam logic [MaskW-1:0] MASK_H = 4'b0011;
  localparam logic [MaskW-1:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StCapture,
    StDone
  } lsu_state_t;

  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane decode: byte-lane mask, replicated store data and extended load data.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]       funct3,
  input  logic [1:0]       off,
  input  logic [DataW-1:0] wdata,
  input  logic [DataW-1:0] rdata_raw,
  output logic [MaskW-1:0] mask,
  output logic [DataW-1:0] wdata_rep,
  output logic [DataW-1:0] rdata_ext
);

  logic [1:0]       lane_off;
  logic [DataW-1:0] shifted;

  // Halves and words are force-aligned; misaligned ones only get here when trapping is off.
  always_comb begin
    lane_off = off;
    if (funct3[1:0] == 2'b01) lane_off[0] = 1'b0;
    if (funct3[1] == 1'b1)    lane_off    = 2'b00;
  end

  assign shifted = rdata_raw >> {lane_off, 3'b000};

  always_comb begin
    mask      = MASK_W;
    wdata_rep = wdata;
    rdata_ext = rdata_raw;
    case (funct3[1:0])
      2'b00: begin
        mask      = MASK_B << lane_off;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = funct3[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        mask      = MASK_H << lane_off;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = funct3[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        mask      = MASK_W;
        wdata_rep = wdata;
        rdata_ext = rdata_raw;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store initiator driving a single-cycle data memory port; all outputs registered.
// Define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic             lsu_store,
  input  logic [2:0]       lsu_funct3,
  input  logic [31:0]      lsu_addr,
  input  logic [DataW-1:0] lsu_wdata,
  output logic             lsu_done,
  output logic [DataW-1:0] lsu_rdata,
  output logic             lsu_err,
  output logic             mem_request,
  output logic             mem_we_re,
  output logic [AddrW-1:0] mem_address,
  output logic [DataW-1:0] mem_data_out,
  output logic [MaskW-1:0] mem_mask,
  input  logic [DataW-1:0] mem_data_in
);

  lsu_state_t       state_q;
  logic             store_q;
  logic [2:0]       funct3_q;
  logic [1:0]       off_q;
  logic             ready_q, done_q, err_q;
  logic [DataW-1:0] rdata_q;
  logic             req_q, we_q;
  logic [AddrW-1:0] maddr_q;
  logic [DataW-1:0] mdata_q;
  logic [MaskW-1:0] mmask_q;

  logic [2:0]       al_funct3;
  logic [1:0]       al_off;
  logic [MaskW-1:0] al_mask;
  logic [DataW-1:0] al_wdata, al_rdata;
  logic             misaligned, accept_err;

  // Addresses wrap modulo 1 KiB.
  logic unused_addr_hi;
  assign unused_addr_hi = ^lsu_addr[31:10];

  // In IDLE the decoder sees the incoming request; afterwards the latched one.
  assign al_funct3 = (state_q == StIdle) ? lsu_funct3 : funct3_q;
  assign al_off    = (state_q == StIdle) ? lsu_addr[1:0] : off_q;

  lsu_align u_align (
    .funct3    (al_funct3),
    .off       (al_off),
    .wdata     (lsu_wdata),
    .rdata_raw (mem_data_in),
    .mask      (al_mask),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((lsu_funct3[1:0] == 2'b01) && lsu_addr[0]) ||
                      ((lsu_funct3[1:0] == 2'b10) && (lsu_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign accept_err = ~f3_legal(lsu_store, lsu_funct3) | misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      mdata_q  <= '0;
      mmask_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (lsu_valid) begin
            store_q  <= lsu_store;
            funct3_q <= lsu_funct3;
            off_q    <= lsu_addr[1:0];
            ready_q  <= 1'b0;
            if (accept_err) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q <= StAccess;
              req_q   <= 1'b1;
              we_q    <= lsu_store;
              maddr_q <= lsu_addr[9:2];
              mdata_q <= lsu_store ? al_wdata : '0;
              mmask_q <= lsu_store ? al_mask : '0;
            end
          end
        end
        StAccess: begin
          req_q   <= 1'b0;
          we_q    <= 1'b0;
          maddr_q <= '0;
          mdata_q <= '0;
          mmask_q <= '0;
          if (store_q) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            state_q <= StCapture;
          end
        end
        StCapture: begin
          rdata_q <= al_rdata;
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= '0;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign lsu_ready    = ready_q;
  assign lsu_done     = done_q;
  assign lsu_err      = err_q;
  assign lsu_rdata    = rdata_q;
  assign mem_request  = req_q;
  assign mem_we_re    = we_q;
  assign mem_address  = maddr_q;
  assign mem_data_out = mdata_q;
  assign mem_mask     = mmask_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a byte-addressed reference memory model.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid, lsu_ready, lsu_store, lsu_done, lsu_err;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        mem_request, mem_we_re;
  logic [7:0]  mem_address;
  logic [31:0] mem_data_out, mem_data_in;
  logic [3:0]  mem_mask;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [256];
  logic [7:0]  ref_mem [1024];

  load_store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_store    (lsu_store),
    .lsu_funct3   (lsu_funct3),
    .lsu_addr     (lsu_addr),
    .lsu_wdata    (lsu_wdata),
    .lsu_done     (lsu_done),
    .lsu_rdata    (lsu_rdata),
    .lsu_err      (lsu_err),
    .mem_request  (mem_request),
    .mem_we_re    (mem_we_re),
    .mem_address  (mem_address),
    .mem_data_out (mem_data_out),
    .mem_mask     (mem_mask),
    .mem_data_in  (mem_data_in)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] seed_word(input int w);
    return 32'h9E37_79B9 * w + 32'h0BAD_F00D;
  endfunction

  // Synchronous single-cycle data memory.
  initial begin
    mem_data_in = '0;
    for (int w = 0; w < 256; w++) mem[w] = seed_word(w);
  end

  always @(posedge clk) begin
    if (mem_request && mem_we_re) begin
      for (int i = 0; i < 4; i++)
        if (mem_mask[i]) mem[mem_address][8*i +: 8] <= mem_data_out[8*i +: 8];
    end
    if (mem_request && !mem_we_re) mem_data_in <= mem[mem_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full access from acceptance to return to IDLE, checked cycle by cycle.
  task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input string tag);
    int          k, n, size;
    logic        legal, mis, err;
    logic [9:0]  ea;
    logic [3:0]  emask;
    logic [31:0] edout, eval;

    size  = int'(f3[1:0]);
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mis   = (size == 1 && addr[0]) || (size == 2 && addr[1:0] != 2'b00);
    err   = !legal || (Trap && mis);
    ea    = addr[9:0];
    if (size == 1) ea[0] = 1'b0;
    if (size == 2) ea[1:0] = 2'b00;
    n     = 1 << size;
    emask = '0;
    edout = '0;
    eval  = '0;
    if (!err) begin
      for (int i = 0; i < n; i++) emask[ea[1:0] + 2'(i)] = 1'b1;
      if (st) begin
        edout = (size == 0) ? {4{wd[7:0]}} : (size == 1) ? {2{wd[15:0]}} : wd;
      end else begin
        for (int i = 0; i < n; i++) eval = eval | (32'(ref_mem[ea + 10'(i)]) << (8 * i));
        if (!f3[2] && size == 0) eval = {{24{eval[7]}}, eval[7:0]};
        if (!f3[2] && size == 1) eval = {{16{eval[15]}}, eval[15:0]};
      end
    end

    k = 0;
    while (!lsu_ready && k < 20) begin
      cyc();
      k++;
    end
    chk({tag, "_ready"}, 32'(lsu_ready), 32'd1);

    lsu_valid  = 1'b1;
    lsu_store  = st;
    lsu_funct3 = f3;
    lsu_addr   = addr;
    lsu_wdata  = wd;
    cyc();
    lsu_valid = 1'b0;

    if (err) begin
      chk({tag, "_err_done"}, 32'(lsu_done), 32'd1);
      chk({tag, "_err_flag"}, 32'(lsu_err), 32'd1);
      chk({tag, "_err_noreq"}, 32'(mem_request), 32'd0);
      cyc();
      chk({tag, "_err_noreq2"}, 32'(mem_request), 32'd0);
    end else begin
      chk({tag, "_req"}, 32'(mem_request), 32'd1);
      chk({tag, "_we"}, 32'(mem_we_re), 32'(st));
      chk({tag, "_maddr"}, 32'(mem_address), 32'(addr[9:2]));
      chk({tag, "_mask"}, 32'(mem_mask), st ? 32'(emask) : 32'd0);
      chk({tag, "_dout"}, mem_data_out, edout);
      chk({tag, "_early_done"}, 32'(lsu_done), 32'd0);
      cyc();
      chk({tag, "_req_drop"}, 32'(mem_request), 32'd0);
      if (!st) begin
        chk({tag, "_cap_nodone"}, 32'(lsu_done), 32'd0);
        cyc();
      end
      chk({tag, "_done"}, 32'(lsu_done), 32'd1);
      chk({tag, "_noerr"}, 32'(lsu_err), 32'd0);
      chk({tag, "_rdata"}, lsu_rdata, eval);
      if (st) for (int i = 0; i < n; i++) ref_mem[ea + 10'(i)] = wd[8*i +: 8];
      cyc();
    end
    chk({tag, "_done_clr"}, 32'(lsu_done), 32'd0);
    chk({tag, "_rdata_clr"}, lsu_rdata, 32'd0);
    chk({tag, "_idle_ready"}, 32'(lsu_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          pulses;
    logic [31:0] w, r_addr;
    logic        r_st;
    logic [2:0]  r_f3;

    for (int wi = 0; wi < 256; wi++) begin
      w = seed_word(wi);
      for (int b = 0; b < 4; b++) ref_mem[4*wi + b] = w[8*b +: 8];
    end

    rst        = 1'b1;
    lsu_valid  = 1'b0;
    lsu_store  = 1'b0;
    lsu_funct3 = 3'b000;
    lsu_addr   = '0;
    lsu_wdata  = '0;
    #1;
    chk("rst_ready", 32'(lsu_ready), 32'd1);
    chk("rst_done", 32'(lsu_done), 32'd0);
    chk("rst_err", 32'(lsu_err), 32'd0);
    chk("rst_rdata", lsu_rdata, 32'd0);
    chk("rst_req", 32'(mem_request), 32'd0);
    chk("rst_mask", 32'(mem_mask), 32'd0);
    chk("rst_dout", mem_data_out, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    access(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, "sw");
    chk("sw_mem_word", mem[4], 32'hDEAD_BEEF);
    access(1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, "sb");
    access(1'b0, 3'b000, 32'h0000_0013, 32'h0, "lb");
    access(1'b0, 3'b100, 32'h0000_0013, 32'h0, "lbu");
    access(1'b1, 3'b001, 32'h0000_0022, 32'h0000_8001, "sh");
    access(1'b0, 3'b001, 32'h0000_0022, 32'h0, "lh");
    access(1'b0, 3'b101, 32'h0000_0022, 32'h0, "lhu");
    access(1'b0, 3'b010, 32'h0000_0402, 32'h0, "lw_mis");
    access(1'b1, 3'b001, 32'h0000_0031, 32'h0000_1234, "sh_mis");
    access(1'b1, 3'b100, 32'h0000_0040, 32'h1111_1111, "st_illegal");
    access(1'b0, 3'b111, 32'h0000_0040, 32'h0, "ld_illegal");

    // Held request: an error access takes two cycles, so three are accepted in six.
    lsu_valid  = 1'b1;
    lsu_store  = 1'b1;
    lsu_funct3 = 3'b100;
    pulses     = 0;
    repeat (6) begin
      cyc();
      if (lsu_done) pulses++;
    end
    lsu_valid = 1'b0;
    chk("b2b_pulses", 32'(pulses), 32'd3);
    chk("b2b_ready", 32'(lsu_ready), 32'd1);

    // Reset during a load ACCESS cycle.
    lsu_valid  = 1'b1;
    lsu_store  = 1'b0;
    lsu_funct3 = 3'b010;
    lsu_addr   = 32'h0000_0008;
    cyc();
    lsu_valid = 1'b0;
    chk("rstmid_req_hi", 32'(mem_request), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_req_lo", 32'(mem_request), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    repeat (4) begin
      cyc();
      if (lsu_done) pulses++;
    end
    chk("rstmid_nodone", 32'(pulses), 32'd0);
    chk("rstmid_ready", 32'(lsu_ready), 32'd1);

    for (int t = 0; t < 60; t++) begin
      r_st   = 1'($urandom_range(0, 1));
      r_f3   = r_st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      r_addr = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 31));
      access(r_st, r_f3, r_addr, $urandom, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
